// File: rtl/peak_search_if.sv
// Bin stream from the round stage plus the per-frame peak result.
interface peak_search_if #(
  parameter int W_IN  = 32,
  parameter int W_IDX = 10
);
  logic signed [W_IN-1:0]  i_data;
  logic                    i_vld;
  logic                    i_sync;
  logic        [W_IDX-1:0] o_peak_idx;
  logic signed [W_IN-1:0]  o_peak_val;
  logic        [W_IN-1:0]  o_peak_mag;
  logic                    o_vld;

  modport master (
    output i_data, i_vld, i_sync,
    input  o_peak_idx, o_peak_val, o_peak_mag, o_vld
  );

  modport slave (
    input  i_data, i_vld, i_sync,
    output o_peak_idx, o_peak_val, o_peak_mag, o_vld
  );
endinterface

// File: rtl/peak_search.sv
// Streaming per-frame peak detector: reports index, value and |value| of the
// largest-magnitude bin in each N-bin frame, one valid pulse per frame.
module peak_search #(
  parameter int W_IN  = 32,
  parameter int N     = 1024,
  parameter int W_IDX = $clog2(N)
) (
  input logic          clk,
  input logic          rst,
  peak_search_if.slave bus
);
  localparam logic [W_IDX-1:0] LAST = W_IDX'(N - 1);

  logic        [W_IDX-1:0] cnt;
  logic        [W_IN-1:0]  mag_in;

  logic                    s1_vld;
  logic        [W_IDX-1:0] s1_idx;
  logic signed [W_IN-1:0]  s1_val;
  logic        [W_IN-1:0]  s1_mag;
  logic                    s1_eof;

  logic        [W_IDX-1:0] run_idx;
  logic signed [W_IN-1:0]  run_val;
  logic        [W_IN-1:0]  run_mag;

  // Two's-complement negate as unsigned: the most negative input maps to 2^(W_IN-1).
  always_comb begin
    mag_in = bus.i_data;
    if (bus.i_data[W_IN-1]) mag_in = ~bus.i_data + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      s1_vld         <= 1'b0;
      s1_idx         <= '0;
      s1_val         <= '0;
      s1_mag         <= '0;
      s1_eof         <= 1'b0;
      run_idx        <= '0;
      run_val        <= '0;
      run_mag        <= '0;
      bus.o_vld      <= 1'b0;
      bus.o_peak_idx <= '0;
      bus.o_peak_val <= '0;
      bus.o_peak_mag <= '0;
    end else begin
      bus.o_vld <= 1'b0;
      s1_vld    <= bus.i_vld;

      if (bus.i_vld) begin
        s1_val <= bus.i_data;
        s1_mag <= mag_in;
        if (bus.i_sync) begin
          s1_idx <= '0;
          s1_eof <= 1'b0;
          cnt    <= W_IDX'(1);
        end else begin
          s1_idx <= cnt;
          s1_eof <= (cnt == LAST);
          cnt    <= cnt + 1'b1;
        end
      end

      // Bin 0 reloads the running max, so a new frame (or a realign) needs no clear cycle.
      if (s1_vld) begin
        if (s1_idx == '0 || s1_mag > run_mag) begin
          run_idx <= s1_idx;
          run_val <= s1_val;
          run_mag <= s1_mag;
        end
        if (s1_eof) begin
          bus.o_vld <= 1'b1;
          if (s1_mag > run_mag) begin
            bus.o_peak_idx <= s1_idx;
            bus.o_peak_val <= s1_val;
            bus.o_peak_mag <= s1_mag;
          end else begin
            bus.o_peak_idx <= run_idx;
            bus.o_peak_val <= run_val;
            bus.o_peak_mag <= run_mag;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_peak_search.sv
// Self-checking bench for peak_search (N=8, W_IN=32): directed vector table,
// hand-written corner sequences and randomized frames against a frame model.
module tb_peak_search;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int WI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  peak_search_if #(.W_IN(W), .W_IDX(WI)) bus ();

  peak_search #(.W_IN(W), .N(N), .W_IDX(WI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] absval(input logic signed [31:0] x);
    longint v;
    v = x;
    if (v < 0) v = -v;
    return 32'(v);
  endfunction

  // Reference model: gathers accepted samples of the current frame and, once
  // N are collected, schedules the argmax-|x| result (lowest index on ties).
  typedef struct {
    int                 due;
    logic [31:0]        idx;
    logic signed [31:0] val;
  } exp_t;

  int                 cyc = 0;
  logic signed [31:0] frame_q[$];
  exp_t               expq[$];
  logic [31:0]        m_idx = '0;
  logic signed [31:0] m_val = '0;
  logic [31:0]        m_mag = '0;
  logic               m_vld = 1'b0;
  bit                 mon_en = 1'b0;
  int                 pulse_cnt = 0;
  int                 pulse_cyc[$];

  always @(posedge clk) begin
    cyc++;
    m_vld = 1'b0;
    if (rst) begin
      frame_q.delete();
      while (expq.size() > 0 && expq[$].due >= cyc) void'(expq.pop_back());
      m_idx = '0;
      m_val = '0;
      m_mag = '0;
    end else begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        m_idx = expq[0].idx;
        m_val = expq[0].val;
        m_mag = absval(expq[0].val);
        m_vld = 1'b1;
        void'(expq.pop_front());
      end
      if (bus.i_vld) begin
        if (bus.i_sync) frame_q.delete();
        frame_q.push_back(bus.i_data);
        if (frame_q.size() == N) begin
          int bi;
          bi = 0;
          for (int i = 1; i < N; i++)
            if (absval(frame_q[i]) > absval(frame_q[bi])) bi = i;
          expq.push_back('{due: cyc + 1, idx: 32'(bi), val: frame_q[bi]});
          frame_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_vld", 32'(bus.o_vld), 32'(m_vld));
      check("mon_idx", 32'(bus.o_peak_idx), m_idx);
      check("mon_val", bus.o_peak_val, m_val);
      check("mon_mag", bus.o_peak_mag, m_mag);
      if (bus.o_vld === 1'b1) begin
        pulse_cnt++;
        pulse_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic signed [31:0] d, input logic s);
    bus.i_data = d;
    bus.i_sync = s;
    bus.i_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_vld  = 1'b0;
    bus.i_sync = 1'b0;
    bus.i_data = 32'($urandom);
  endtask

  // Idle cycles carry junk data and stray i_sync with i_vld low.
  task automatic idle(input int n);
    repeat (n) begin
      bus.i_sync = 1'($urandom_range(1));
      @(posedge clk);
      #1;
    end
    bus.i_sync = 1'b0;
  endtask

  task automatic wait_vld(output bit got, output int lat);
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (bus.o_vld === 1'b1) begin
        got = 1'b1;
        lat = k + 1;
        return;
      end
    end
  endtask

  typedef struct {
    logic signed [31:0] s[N];
    logic [31:0]        idx;
    logic signed [31:0] val;
    logic [31:0]        mag;
    bit                 gaps;
  } vec_t;

  vec_t tv[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit got;
    int lat;

    tv[0] = '{'{32'sd3, -32'sd7, 32'sd5, 32'sd0, 32'sd7, 32'sd2, -32'sd1, 32'sd1},
              32'd1, -32'sd7, 32'd7, 1'b0};
    tv[1] = '{'{32'sd1, -32'sd2, 32'sd3, -32'sd4, 32'sd0, 32'sh80000000, 32'sd5, 32'sd6},
              32'd5, 32'sh80000000, 32'h80000000, 1'b0};
    tv[2] = '{'{32'sd1, 32'sd2, -32'sd3, 32'sd42, -32'sd41, 32'sd0, 32'sd7, -32'sd42},
              32'd3, 32'sd42, 32'd42, 1'b1};
    tv[3] = '{'{32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd100},
              32'd7, 32'sd100, 32'd100, 1'b0};

    bus.i_data = '0;
    bus.i_vld  = 1'b0;
    bus.i_sync = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_vld", 32'(bus.o_vld), 32'd0);
    check("reset_idx", 32'(bus.o_peak_idx), 32'd0);
    check("reset_val", bus.o_peak_val, 32'd0);
    check("reset_mag", bus.o_peak_mag, 32'd0);

    // Directed vector table
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < N; i++) begin
        if (tv[v].gaps && $urandom_range(1) == 1) idle(int'($urandom_range(1, 3)));
        send(tv[v].s[i], 1'b0);
      end
      wait_vld(got, lat);
      check("tbl_got", 32'(got), 32'd1);
      check("tbl_latency", 32'(lat), 32'd2);
      check("tbl_idx", 32'(bus.o_peak_idx), tv[v].idx);
      check("tbl_val", bus.o_peak_val, tv[v].val);
      check("tbl_mag", bus.o_peak_mag, tv[v].mag);
      idle(5);
      check("tbl_hold_idx", 32'(bus.o_peak_idx), tv[v].idx);
      check("tbl_hold_val", bus.o_peak_val, tv[v].val);
    end

    // Back-to-back frames: pulses 8 cycles apart, first max must not leak
    pulse_cnt = 0;
    pulse_cyc.delete();
    for (int i = 0; i < N; i++) send((i == 0) ? 32'sd500 : 32'sd1, 1'b0);
    for (int i = 0; i < N; i++) send((i == 7) ? 32'sd100 : 32'sd0, 1'b0);
    idle(5);
    check("b2b_count", 32'(pulse_cnt), 32'd2);
    if (pulse_cyc.size() == 2) check("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd8);
    check("b2b_idx", 32'(bus.o_peak_idx), 32'd7);
    check("b2b_val", bus.o_peak_val, 32'sd100);

    // Realign mid-frame: partial frame yields nothing
    pulse_cnt = 0;
    send(32'sd1000, 1'b0);
    send(-32'sd1000, 1'b0);
    send(32'sd999, 1'b0);
    begin
      logic signed [31:0] fr[N];
      fr = '{32'sd1, 32'sd2, -32'sd3, 32'sd0, 32'sd4, -32'sd5, -32'sd9, 32'sd8};
      for (int i = 0; i < N; i++) send(fr[i], i == 0);
    end
    idle(4);
    check("sync_count", 32'(pulse_cnt), 32'd1);
    check("sync_idx", 32'(bus.o_peak_idx), 32'd6);
    check("sync_val", bus.o_peak_val, -32'sd9);
    check("sync_mag", bus.o_peak_mag, 32'd9);

    // Reset mid-frame
    pulse_cnt = 0;
    for (int i = 0; i < 5; i++) send(32'sd77, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_vld", 32'(bus.o_vld), 32'd0);
    check("rst_idx", 32'(bus.o_peak_idx), 32'd0);
    check("rst_val", bus.o_peak_val, 32'd0);
    check("rst_mag", bus.o_peak_mag, 32'd0);
    begin
      logic signed [31:0] fr[N];
      fr = '{32'sd2, 32'sd0, 32'sd0, -32'sd6, 32'sd0, 32'sd6, 32'sd0, 32'sd1};
      for (int i = 0; i < N; i++) send(fr[i], 1'b0);
    end
    idle(4);
    check("rst_count", 32'(pulse_cnt), 32'd1);
    check("rst_new_idx", 32'(bus.o_peak_idx), 32'd3);
    check("rst_new_val", bus.o_peak_val, -32'sd6);

    // Randomized frames with gaps, realigns and occasional resets
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < N; i++) begin
        logic signed [31:0] d;
        case ($urandom_range(7))
          0:       d = 32'sh80000000;
          1:       d = 32'sh7fffffff;
          2:       d = 32'(int'($urandom_range(20)) - 10);
          default: d = 32'($urandom);
        endcase
        if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
        send(d, $urandom_range(15) == 0);
      end
      if ($urandom_range(19) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
